// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core ports, the arbiter and the unified memory.
// The perf counter outputs exist only when MEM_ARB_PERF_EN is defined.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [DW-1:0] imem_resp_rdata;

  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic [AW-1:0]   dmem_req_addr;
  logic            dmem_req_wr;
  logic [DW-1:0]   dmem_req_wdata;
  logic [DW/8-1:0] dmem_req_wmask;
  logic            dmem_resp_valid;
  logic [DW-1:0]   dmem_resp_rdata;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_req_addr;
  logic            mem_req_wr;
  logic [DW-1:0]   mem_req_wdata;
  logic [DW/8-1:0] mem_req_wmask;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_resp_rdata;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_imem_grants;
  logic [31:0] perf_dmem_grants;
  logic [31:0] perf_imem_stall;
`endif

  // Arbiter side: it serves both requesters and drives the memory request.
  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  dmem_req_valid, dmem_req_addr, dmem_req_wr, dmem_req_wdata, dmem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output imem_req_ready, imem_resp_valid, imem_resp_rdata,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_wr, mem_req_wdata, mem_req_wmask
`ifdef MEM_ARB_PERF_EN
    , output perf_imem_grants, perf_dmem_grants, perf_imem_stall
`endif
  );

  modport master (
    output imem_req_valid, imem_req_addr,
    output dmem_req_valid, dmem_req_addr, dmem_req_wr, dmem_req_wdata, dmem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  imem_req_ready, imem_resp_valid, imem_resp_rdata,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_wr, mem_req_wdata, mem_req_wmask
`ifdef MEM_ARB_PERF_EN
    , input perf_imem_grants, perf_dmem_grants, perf_imem_stall
`endif
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data ports, one transaction in flight.
// Optional perf counters (grants, imem stall cycles) are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_DMEM_STREAK = 4
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IMEM, OWN_DMEM} owner_t;

  localparam int SW = (MAX_DMEM_STREAK < 2) ? 1 : $clog2(MAX_DMEM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DMEM_STREAK);

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  logic [SW-1:0]   streak_q, streak_d;

  logic            dmemWins;
  logic            handshake;
  logic            reqValid;
  logic            readyImem, readyDmem;
  logic            respImem, respDmem;
  logic [AW-1:0]   winAddr;
  logic            winWr;
  logic [DW-1:0]   winWdata;
  logic [DW/8-1:0] winWmask;

  // Dmem has priority unless it has starved a waiting fetch for MAX_DMEM_STREAK grants.
  always_comb begin
    dmemWins = bus.dmem_req_valid & (~bus.imem_req_valid | (streak_q != STREAK_MAX));
    winAddr  = bus.imem_req_addr;
    winWr    = 1'b0;
    winWdata = '0;
    winWmask = '0;
    if (dmemWins) begin
      winAddr  = bus.dmem_req_addr;
      winWr    = bus.dmem_req_wr;
      winWdata = bus.dmem_req_wdata;
      winWmask = bus.dmem_req_wmask;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    streak_d  = streak_q;
    reqValid  = 1'b0;
    readyImem = 1'b0;
    readyDmem = 1'b0;
    respImem  = 1'b0;
    respDmem  = 1'b0;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        reqValid  = bus.imem_req_valid | bus.dmem_req_valid;
        readyDmem = dmemWins & bus.mem_req_ready;
        readyImem = bus.imem_req_valid & ~dmemWins & bus.mem_req_ready;
        handshake = reqValid & bus.mem_req_ready;
        if (handshake) begin
          state_d = BUSY;
          owner_d = dmemWins ? OWN_DMEM : OWN_IMEM;
          if (dmemWins && bus.imem_req_valid)
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
          else
            streak_d = '0;
        end
      end
      BUSY: begin
        respImem = (owner_q == OWN_IMEM) & bus.mem_resp_valid;
        respDmem = (owner_q == OWN_DMEM) & bus.mem_resp_valid;
        if (bus.mem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IMEM;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  assign bus.mem_req_valid   = reqValid;
  assign bus.mem_req_addr    = winAddr;
  assign bus.mem_req_wr      = winWr;
  assign bus.mem_req_wdata   = winWdata;
  assign bus.mem_req_wmask   = winWmask;
  assign bus.imem_req_ready  = readyImem;
  assign bus.dmem_req_ready  = readyDmem;
  assign bus.imem_resp_valid = respImem;
  assign bus.dmem_resp_valid = respDmem;
  assign bus.imem_resp_rdata = bus.mem_resp_rdata;
  assign bus.dmem_resp_rdata = bus.mem_resp_rdata;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perfImemGrants_q, perfDmemGrants_q, perfImemStall_q;

  // Observation only; counters wrap naturally and never feed back into arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfImemGrants_q <= '0;
      perfDmemGrants_q <= '0;
      perfImemStall_q  <= '0;
    end else begin
      if (handshake && !dmemWins) perfImemGrants_q <= perfImemGrants_q + 32'd1;
      if (handshake && dmemWins)  perfDmemGrants_q <= perfDmemGrants_q + 32'd1;
      if (bus.imem_req_valid && !readyImem) perfImemStall_q <= perfImemStall_q + 32'd1;
    end
  end

  assign bus.perf_imem_grants = perfImemGrants_q;
  assign bus.perf_dmem_grants = perfDmemGrants_q;
  assign bus.perf_imem_stall  = perfImemStall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the memory is modelled by hand-driven responses.
// Define MEM_ARB_PERF_EN for both files to also check the perf counters.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   errCount;
  int   checkCount;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .MAX_DMEM_STREAK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                               input logic dv, input logic [31:0] da, input logic dwr,
                               input logic [31:0] dwd, input logic [3:0] dwm,
                               input logic mrdy, input logic mrv, input logic [31:0] mrd);
    bus.imem_req_valid = iv;
    bus.imem_req_addr  = ia;
    bus.dmem_req_valid = dv;
    bus.dmem_req_addr  = da;
    bus.dmem_req_wr    = dwr;
    bus.dmem_req_wdata = dwd;
    bus.dmem_req_wmask = dwm;
    bus.mem_req_ready  = mrdy;
    bus.mem_resp_valid = mrv;
    bus.mem_resp_rdata = mrd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  logic expectDmem;

  initial begin
    errCount   = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("rst mem_req_valid", 64'(bus.mem_req_valid), 0);
    checkOutput("rst imem_req_ready", 64'(bus.imem_req_ready), 0);
    checkOutput("rst dmem_req_ready", 64'(bus.dmem_req_ready), 0);
    checkOutput("rst imem_resp_valid", 64'(bus.imem_resp_valid), 0);
    checkOutput("rst dmem_resp_valid", 64'(bus.dmem_resp_valid), 0);
`ifdef MEM_ARB_PERF_EN
    checkOutput("rst perf_imem_grants", 64'(bus.perf_imem_grants), 0);
`endif
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Fetch only, response two cycles after the grant.
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("s1 mem_req_valid", 64'(bus.mem_req_valid), 1);
    checkOutput("s1 mem_req_addr", 64'(bus.mem_req_addr), 64'h100);
    checkOutput("s1 mem_req_wr", 64'(bus.mem_req_wr), 0);
    checkOutput("s1 imem_req_ready", 64'(bus.imem_req_ready), 1);
    checkOutput("s1 dmem_req_ready", 64'(bus.dmem_req_ready), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("s1 busy mem_req_valid", 64'(bus.mem_req_valid), 0);
    checkOutput("s1 busy imem_resp_valid", 64'(bus.imem_resp_valid), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF);
    checkOutput("s1 imem_resp_valid", 64'(bus.imem_resp_valid), 1);
    checkOutput("s1 imem_resp_rdata", 64'(bus.imem_resp_rdata), 64'hDEADBEEF);
    checkOutput("s1 dmem_resp_valid", 64'(bus.dmem_resp_valid), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("s1 resp one cycle", 64'(bus.imem_resp_valid), 0);

    // Simultaneous requests: the store wins, the fetch follows after the response.
    applyStimulus(1, 32'h300, 1, 32'h200, 1, 32'h12345678, 4'hF, 1, 0, 0);
    checkOutput("s2 dmem_req_ready", 64'(bus.dmem_req_ready), 1);
    checkOutput("s2 imem_req_ready", 64'(bus.imem_req_ready), 0);
    checkOutput("s2 mem_req_wr", 64'(bus.mem_req_wr), 1);
    checkOutput("s2 mem_req_addr", 64'(bus.mem_req_addr), 64'h200);
    checkOutput("s2 mem_req_wdata", 64'(bus.mem_req_wdata), 64'h12345678);
    checkOutput("s2 mem_req_wmask", 64'(bus.mem_req_wmask), 64'hF);
    tick();
    applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 1, 1, 32'h55);
    checkOutput("s2 dmem_resp_valid", 64'(bus.dmem_resp_valid), 1);
    checkOutput("s2 imem_resp_valid busy", 64'(bus.imem_resp_valid), 0);
    checkOutput("s2 imem_req_ready busy", 64'(bus.imem_req_ready), 0);
    checkOutput("s2 mem_req_valid busy", 64'(bus.mem_req_valid), 0);
    tick();
    applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("s2 imem_req_ready", 64'(bus.imem_req_ready), 1);
    checkOutput("s2 imem addr", 64'(bus.mem_req_addr), 64'h300);
    checkOutput("s2 imem wr", 64'(bus.mem_req_wr), 0);
    checkOutput("s2 imem wdata", 64'(bus.mem_req_wdata), 0);
    checkOutput("s2 imem wmask", 64'(bus.mem_req_wmask), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h77);
    checkOutput("s2 imem_resp_valid", 64'(bus.imem_resp_valid), 1);
    checkOutput("s2 dmem_resp_valid idle", 64'(bus.dmem_resp_valid), 0);
    tick();

    // Continuous contention from a fresh reset: expected order D,D,D,D,I,D,D,D,D,I.
    pulseReset();
    for (int g = 0; g < 10; g++) begin
      expectDmem = ((g % 5) != 4);
      applyStimulus(1, 32'h1000, 1, 32'h2000, 0, 0, 0, 1, 0, 0);
      checkOutput($sformatf("s3 grant%0d dmem_ready", g), 64'(bus.dmem_req_ready), 64'(expectDmem));
      checkOutput($sformatf("s3 grant%0d imem_ready", g), 64'(bus.imem_req_ready), 64'(!expectDmem));
      tick();
      applyStimulus(1, 32'h1000, 1, 32'h2000, 0, 0, 0, 1, 1, 32'h9);
      tick();
    end
`ifdef MEM_ARB_PERF_EN
    checkOutput("perf_dmem_grants", 64'(bus.perf_dmem_grants), 8);
    checkOutput("perf_imem_grants", 64'(bus.perf_imem_grants), 2);
    checkOutput("perf_imem_stall", 64'(bus.perf_imem_stall), 18);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Memory back-pressure for three cycles; the request must wait in IDLE.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 0, 1, 32'h400, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("s4 stall%0d dmem_ready", c), 64'(bus.dmem_req_ready), 0);
      checkOutput($sformatf("s4 stall%0d mem_req_valid", c), 64'(bus.mem_req_valid), 1);
      checkOutput($sformatf("s4 stall%0d addr", c), 64'(bus.mem_req_addr), 64'h400);
      tick();
    end
    applyStimulus(0, 0, 1, 32'h400, 0, 0, 0, 1, 0, 0);
    checkOutput("s4 dmem_ready", 64'(bus.dmem_req_ready), 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hAB);
    checkOutput("s4 dmem_resp_valid", 64'(bus.dmem_resp_valid), 1);
    checkOutput("s4 dmem_resp_rdata", 64'(bus.dmem_resp_rdata), 64'hAB);
    tick();

    // Reset while a fetch is outstanding, then a stale response must be ignored.
    applyStimulus(1, 32'h600, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("s5 imem granted", 64'(bus.imem_req_ready), 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11);
    rst_n = 1'b0;
    #1;
    checkOutput("s5 rst imem_resp_valid", 64'(bus.imem_resp_valid), 0);
    checkOutput("s5 rst dmem_resp_valid", 64'(bus.dmem_resp_valid), 0);
    checkOutput("s5 rst mem_req_valid", 64'(bus.mem_req_valid), 0);
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h22);
    checkOutput("s5 stale imem_resp_valid", 64'(bus.imem_resp_valid), 0);
    checkOutput("s5 stale dmem_resp_valid", 64'(bus.dmem_resp_valid), 0);
    tick();
    applyStimulus(0, 0, 1, 32'h500, 0, 0, 0, 1, 0, 0);
    checkOutput("s5 dmem_req_ready", 64'(bus.dmem_req_ready), 1);
    checkOutput("s5 mem_req_wr", 64'(bus.mem_req_wr), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hCAFEF00D);
    checkOutput("s5 dmem_resp_valid", 64'(bus.dmem_resp_valid), 1);
    checkOutput("s5 dmem_resp_rdata", 64'(bus.dmem_resp_rdata), 64'hCAFEF00D);
    checkOutput("s5 imem_resp_valid", 64'(bus.imem_resp_valid), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
